// File: rtl/card_shoe.sv
// card_shoe: single-deck card source, deals 0-51 without replacement.
// LFSR candidates for a bounded number of tries, then a linear probe guarantees a deal.
module card_shoe #(
   parameter int          MAX_TRIES     = 8,
   parameter logic [15:0] FALLBACK_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        shuffle,
   input  logic [15:0] seed,
   input  logic        req,
   output logic [7:0]  card,
   output logic        card_valid,
   output logic [5:0]  cards_left,
   output logic        empty,
   output logic        busy,
   output logic        req_err
);
   typedef enum logic [1:0] {IDLE, DRAW, PROBE} state_t;
   state_t      state, state_n;
   logic [51:0] dealt;
   logic [63:0] dealt_x;
   logic [15:0] lfsr;
   logic [5:0]  tries, probe, cand, code;
   logic        cand_ok, probe_ok, last, deal;
   assign dealt_x = {12'b0, dealt};
   assign empty   = cards_left == 6'd0;
   assign busy    = state != IDLE;
   always_comb begin
      cand     = lfsr[5:0];
      cand_ok  = cand < 6'd52 && !dealt_x[cand];
      probe_ok = !dealt_x[probe];
      last     = tries == 6'(MAX_TRIES - 1);
      deal     = (state == DRAW && cand_ok) || (state == PROBE && probe_ok);
      code     = state == DRAW ? cand : probe;
      state_n  = state == IDLE ? (req && !empty ? DRAW : IDLE)
               : state == DRAW ? (cand_ok ? IDLE : last ? PROBE : DRAW)
               : (probe_ok ? IDLE : PROBE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dealt      <= '0;
         cards_left <= 6'd52;
         lfsr       <= FALLBACK_SEED;
         card       <= '0;
         card_valid <= 1'b0;
         req_err    <= 1'b0;
         tries      <= '0;
         probe      <= '0;
      end else if (shuffle) begin
         state      <= IDLE;
         dealt      <= '0;
         cards_left <= 6'd52;
         lfsr       <= seed == 16'd0 ? FALLBACK_SEED : seed;
         card_valid <= 1'b0;
         req_err    <= 1'b0;
      end else begin
         state      <= state_n;
         card_valid <= deal;
         req_err    <= state == IDLE && req && empty;
         tries      <= state == DRAW ? tries + 6'd1 : 6'd0;
         if (state == DRAW)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         if (state == DRAW && !cand_ok && last)
            probe <= cand >= 6'd52 ? cand - 6'd52 : cand;
         else if (state == PROBE && !probe_ok)
            probe <= probe == 6'd51 ? 6'd0 : probe + 6'd1;
         if (deal) begin
            dealt[code] <= 1'b1;
            card        <= {2'b00, code};
            cards_left  <= cards_left - 6'd1;
         end
      end
   end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: randomized checks of card_shoe (MAX_TRIES 8 and 1) against a behavioural deck model.
module tb_card_shoe;
   logic        clk = 1'b0;
   logic        rst_v[2], shuffle_v[2], req_v[2];
   logic [15:0] seed_v[2];
   logic [7:0]  card_v[2];
   logic        cv_v[2], empty_v[2], busy_v[2], err_v[2];
   logic [5:0]  left_v[2];
   int          checks = 0, errors = 0;
   logic [51:0] m_dealt[2];
   logic [15:0] m_lfsr[2];
   int          m_left[2];
   always #5 clk = ~clk;
   card_shoe u0 (.clk(clk), .rst(rst_v[0]), .shuffle(shuffle_v[0]), .seed(seed_v[0]), .req(req_v[0]),
                 .card(card_v[0]), .card_valid(cv_v[0]), .cards_left(left_v[0]), .empty(empty_v[0]),
                 .busy(busy_v[0]), .req_err(err_v[0]));
   card_shoe #(.MAX_TRIES(1)) u1 (.clk(clk), .rst(rst_v[1]), .shuffle(shuffle_v[1]), .seed(seed_v[1]),
                 .req(req_v[1]), .card(card_v[1]), .card_valid(cv_v[1]), .cards_left(left_v[1]),
                 .empty(empty_v[1]), .busy(busy_v[1]), .req_err(err_v[1]));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction
   task automatic model_reset(input int i, input logic [15:0] s);
      m_dealt[i] = '0;
      m_left[i]  = 52;
      m_lfsr[i]  = s == 16'd0 ? 16'hACE1 : s;
   endtask
   // Predicts the next dealt card and the req-to-card_valid distance in cycles.
   task automatic model_draw(input int i, input bit commit, output logic [7:0] c, output int lat);
      logic [15:0] l;
      logic [51:0] d;
      int mt, cand, p;
      l = m_lfsr[i]; d = m_dealt[i]; mt = i ? 1 : 8; lat = -1; cand = 0; c = 0;
      for (int t = 0; t < mt && lat < 0; t++) begin
         cand = int'(l[5:0]);
         l = step(l);
         if (cand < 52 && !d[cand]) begin c = 8'(cand); lat = t + 2; end
      end
      if (lat < 0) begin
         p = cand >= 52 ? cand - 52 : cand;
         for (int k = 0; k < 52 && lat < 0; k++)
            if (!d[p]) begin c = 8'(p); lat = mt + 2 + k; end
            else p = p == 51 ? 0 : p + 1;
      end
      if (commit) begin
         d[c[5:0]] = 1'b1;
         m_dealt[i] = d; m_lfsr[i] = l; m_left[i]--;
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_v[0] = 1; rst_v[1] = 1;
      @(negedge clk);
      rst_v[0] = 0; rst_v[1] = 0;
      model_reset(0, 16'd0);
      model_reset(1, 16'd0);
   endtask
   task automatic do_shuffle(input int i, input logic [15:0] s);
      @(negedge clk);
      shuffle_v[i] = 1; seed_v[i] = s;
      @(negedge clk);
      shuffle_v[i] = 0; seed_v[i] = $urandom;
      model_reset(i, s);
      check("shuf_left", left_v[i], 52);
      check("shuf_busy", busy_v[i], 0);
   endtask
   task automatic draw(input int i, input int hold, output logic [7:0] c, output int n);
      int el, bc, extra;
      logic got;
      model_draw(i, 1, c, el);
      @(negedge clk);
      req_v[i] = 1; n = 0; bc = 0; got = 0; extra = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (n >= hold) req_v[i] = 0;
         if (busy_v[i]) bc++;
         got = cv_v[i];
      end
      req_v[i] = 0;
      check("latency", n, el);
      check("card", card_v[i], c);
      check("left", left_v[i], m_left[i]);
      check("empty", empty_v[i], m_left[i] == 0);
      check("busy_cycles", bc, el - 1);
      repeat (2) begin
         @(negedge clk);
         if (cv_v[i]) extra++;
      end
      check("extra_valid", extra, 0);
   endtask
   initial begin
      logic [7:0]  c;
      logic [51:0] seen;
      int          n, el, cnt, found;
      for (int i = 0; i < 2; i++) begin
         rst_v[i] = 0; shuffle_v[i] = 0; req_v[i] = 0; seed_v[i] = 0;
      end
      do_reset();
      check("rst_card", card_v[0], 0);
      check("rst_left", left_v[0], 52);
      check("rst_busy", busy_v[0], 0);
      check("rst_valid", cv_v[0], 0);
      check("rst_empty", empty_v[0], 0);
      draw(0, 1, c, n);
      check("first_card", c, 33);
      seen = '0;
      seen[c[5:0]] = 1'b1;
      for (int k = 1; k < 52; k++) begin
         draw(0, $urandom_range(1, 2), c, n);
         seen[c[5:0]] = 1'b1;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      check("deck_cover", seen, {52{1'b1}});
      check("deck_empty", empty_v[0], 1);
      @(negedge clk);
      req_v[0] = 1;
      @(negedge clk);
      req_v[0] = 0;
      check("req_err", err_v[0], 1);
      check("err_novalid", cv_v[0], 0);
      @(negedge clk);
      check("req_err_pulse", err_v[0], 0);
      check("err_left", left_v[0], 0);
      check("err_busy", busy_v[0], 0);
      for (int r = 0; r < 2; r++) begin
         do_shuffle(0, 16'h1234);
         for (int k = 0; k < 10; k++) draw(0, 1, c, n);
      end
      do_shuffle(0, 16'h0000);
      draw(0, 1, c, n);
      check("seed0_first", c, 33);
      seen = '0;
      do_shuffle(1, 16'($urandom_range(1, 65535)));
      for (int k = 0; k < 52; k++) begin
         draw(1, 1, c, n);
         seen[c[5:0]] = 1'b1;
         check("lat_bound", n <= 54, 1);
      end
      check("mt1_cover", seen, {52{1'b1}});
      check("mt1_empty", empty_v[1], 1);
      do_shuffle(0, 16'($urandom));
      @(negedge clk);
      req_v[0] = 1;
      @(negedge clk);
      req_v[0] = 0; shuffle_v[0] = 1; seed_v[0] = 16'h5A5A;
      @(negedge clk);
      shuffle_v[0] = 0;
      model_reset(0, 16'h5A5A);
      cnt = 0;
      repeat (4) begin
         if (cv_v[0]) cnt++;
         @(negedge clk);
      end
      check("abort_valid", cnt, 0);
      check("abort_left", left_v[0], 52);
      check("abort_busy", busy_v[0], 0);
      draw(0, 2, c, n);
      @(negedge clk);
      req_v[0] = 1; shuffle_v[0] = 1; seed_v[0] = 16'h0F0F;
      @(negedge clk);
      req_v[0] = 0; shuffle_v[0] = 0;
      model_reset(0, 16'h0F0F);
      cnt = 0;
      repeat (3) begin
         if (busy_v[0] || cv_v[0]) cnt++;
         @(negedge clk);
      end
      check("shuf_req_idle", cnt, 0);
      draw(0, 1, c, n);
      do_shuffle(1, 16'($urandom_range(1, 65535)));
      found = 0;
      for (int k = 0; k < 51 && !found; k++) begin
         model_draw(1, 0, c, el);
         if (el >= 4) begin
            found = 1;
            @(negedge clk);
            req_v[1] = 1;
            @(negedge clk);
            req_v[1] = 0;
            @(negedge clk);
            check("probe_busy", busy_v[1], 1);
            rst_v[1] = 1;
            @(negedge clk);
            rst_v[1] = 0;
            model_reset(1, 16'd0);
            check("mid_rst_card", card_v[1], 0);
            check("mid_rst_valid", cv_v[1], 0);
            check("mid_rst_left", left_v[1], 52);
            check("mid_rst_busy", busy_v[1], 0);
            check("mid_rst_err", err_v[1], 0);
            draw(1, 1, c, n);
            check("mid_rst_first", c, 33);
         end else draw(1, 1, c, n);
      end
      check("probe_found", found, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
Single-deck card source that deals cards without replacement, one per request, on a valid pulse. Cards use the standard 0-51 code: suit order Hearts, Diamonds, Clubs, Spades; rank = code % 13, Ace = 0. It is the producer side of the dealing path and feeds the dealer and player hand evaluators one card at a time. The source is a seedable 16-bit LFSR, with a bounded search and a linear-probe fallback so every draw terminates.

Parameters:
MAX_TRIES, 8, LFSR candidates tried per draw before falling back to linear probe (1..63)
FALLBACK_SEED, 16'hACE1, LFSR value loaded on rst, or on shuffle when seed==0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
shuffle  input  1  restores all 52 cards, loads LFSR from seed, aborts any draw in progress
seed  input  16  LFSR seed, sampled only when shuffle=1
req  input  1  single-cycle draw request
card  output  8  dealt card code 0-51; holds until the next deal
card_valid  output  1  one-cycle pulse, card is new this cycle
cards_left  output  6  undealt card count, 0-52
empty  output  1  cards_left==0
busy  output  1  draw in progress, req ignored
req_err  output  1  one-cycle pulse, req received while empty

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - dealt mask = 52'b0, cards_left = 52, lfsr = FALLBACK_SEED, card = 0.
  - card_valid = 0, req_err = 0, busy = 0, state = IDLE.
- Priority: rst > shuffle > req.
- LFSR: Galois, right shift. Next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). Advances only in DRAW, one step per DRAW cycle. Never 0.
- States: IDLE, DRAW, PROBE.
- IDLE:
  - req && !empty -> DRAW, tries = 0.
  - req && empty -> req_err = 1 next cycle, stay IDLE, no card_valid.
- DRAW (busy = 1): cand = lfsr[5:0]; lfsr advances this cycle.
  - If cand < 52 && !dealt[cand]: set dealt[cand], card <= cand, card_valid = 1 next cycle, cards_left decrements by 1, go IDLE.
  - Else if tries == MAX_TRIES-1: probe <= (cand >= 52 ? cand-52 : cand), go PROBE.
  - Else tries++.
- PROBE (busy = 1):
  - If !dealt[probe]: deal probe exactly as in DRAW, go IDLE.
  - Else probe <= (probe == 51 ? 0 : probe+1).
  - Terminates within 52 cycles because cards_left > 0.
- Latency: best case card_valid 2 cycles after req (req cycle 0, DRAW cycle 1, card_valid cycle 2). Worst case 2 + MAX_TRIES + 51 cycles.
- Requests:
  - req while busy is ignored; no queueing, no req_err.
  - req in the same cycle as card_valid is accepted normally (state is IDLE).
- shuffle:
  - Effect: dealt = 0, cards_left = 52, lfsr = (seed == 0 ? FALLBACK_SEED : seed), state = IDLE.
  - Any draw in DRAW or PROBE is dropped: no card_valid, no count change.
  - card keeps its old value.
  - shuffle together with req: req is dropped.
- Width rules: cand is a 6-bit compare against 52. cards_left never wraps; it is only decremented on a successful deal.
- Invariant: cards_left == 52 - popcount(dealt) at all times.

Test Plan:
- rst, then req at cycle 0 -> card_valid at cycle 2, card = 33 (ACE1[5:0]), cards_left = 51, busy high for exactly 1 cycle.
- rst, then 52 reqs each issued after the previous card_valid -> 52 distinct codes covering 0-51, cards_left counts down to 0, empty = 1. 53rd req -> req_err pulse, no card_valid, cards_left stays 0.
- shuffle with seed = 16'h1234, deal 10 cards, then shuffle 16'h1234 again and deal 10 -> identical sequence both times. shuffle with seed = 0 -> same sequence as after rst (first card 33).
- MAX_TRIES = 1, deal the full deck -> all 52 distinct, each draw finishes within 54 cycles of req, and the PROBE wrap 51 -> 0 is exercised.
- req, then shuffle asserted 1 cycle later (during DRAW) -> no card_valid, cards_left = 52, busy = 0. Also: req repeated while busy -> ignored, exactly one card_valid.
- rst asserted mid-PROBE -> next cycle all outputs at reset values. shuffle and req together in IDLE -> no draw starts, busy stays 0.
